// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and owner encoding for the video RAM arbiter
package vram_pkg;
    localparam int AW = 14;
    localparam int DW = 8;

    localparam logic [1:0] VID_SLOT = 2'd0;

    // Used both for the combinational issue select and the registered pending tag
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);
    // 1 = requester 1 won most recently, so requester 0 takes the next tie
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (|o_grant) begin
            r_last <= o_grant[1];
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM shared by scanout, CPU and DMA
module vram_arbiter #(
    parameter int AW = vram_pkg::AW,
    parameter int DW = vram_pkg::DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_vid_phase,
    input  logic          i_vid_en,
    input  logic [AW-1:0] i_vid_addr,
    output logic [DW-1:0] o_vid_data,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_ack,
    input  logic          i_dma_req,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    output logic [DW-1:0] o_dma_rdata,
    output logic          o_dma_ack,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);
    import vram_pkg::*;

    logic          w_vid_own;
    logic [1:0]    w_elig;
    logic [1:0]    w_grant;
    owner_e        w_own;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [DW-1:0] w_wdata;
    logic          w_cpu_rd_done;
    logic          w_dma_rd_done;

    owner_e        r_tag;
    logic          r_we_pend;
    logic [AW-1:0] r_addr_hold;
    logic [DW-1:0] r_vid_data;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;

    assign w_vid_own = i_vid_en && (i_vid_phase == VID_SLOT);

    // The port served last cycle sits out one cycle, so its ack cycle is never reissued
    assign w_elig = {i_dma_req && (r_tag != OWN_DMA),
                     i_cpu_req && (r_tag != OWN_CPU)};

    rr_arb2 u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_elig),
        .i_en    (!w_vid_own),
        .o_grant (w_grant)
    );

    always_comb begin
        w_own   = OWN_NONE;
        w_addr  = r_addr_hold;
        w_we    = 1'b0;
        w_wdata = '0;
        if (w_vid_own) begin
            w_own  = OWN_VID;
            w_addr = i_vid_addr;
        end else if (w_grant[0]) begin
            w_own   = OWN_CPU;
            w_addr  = i_cpu_addr;
            w_we    = i_cpu_we;
            w_wdata = i_cpu_wdata;
        end else if (w_grant[1]) begin
            w_own   = OWN_DMA;
            w_addr  = i_dma_addr;
            w_we    = i_dma_we;
            w_wdata = i_dma_wdata;
        end
    end

    assign o_ram_addr  = w_addr;
    assign o_ram_we    = w_we && i_rst_n;
    assign o_ram_wdata = w_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag       <= OWN_NONE;
            r_we_pend   <= 1'b0;
            r_addr_hold <= '0;
            r_vid_data  <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_tag       <= w_own;
            r_we_pend   <= w_we;
            r_addr_hold <= w_addr;
            if (r_tag == OWN_VID) begin
                r_vid_data <= i_ram_rdata;
            end
            if (w_cpu_rd_done) begin
                r_cpu_rdata <= i_ram_rdata;
            end
            if (w_dma_rd_done) begin
                r_dma_rdata <= i_ram_rdata;
            end
        end
    end

    assign o_cpu_ack     = (r_tag == OWN_CPU);
    assign o_dma_ack     = (r_tag == OWN_DMA);
    assign w_cpu_rd_done = o_cpu_ack && !r_we_pend;
    assign w_dma_rd_done = o_dma_ack && !r_we_pend;

    // Read data is presented straight from the RAM alongside ack, then held
    assign o_cpu_rdata = w_cpu_rd_done ? i_ram_rdata : r_cpu_rdata;
    assign o_dma_rdata = w_dma_rd_done ? i_ram_rdata : r_dma_rdata;
    assign o_vid_data  = r_vid_data;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized scoreboard bench for vram_arbiter
module tb_vram_arbiter;
    localparam int M_NONE = 0;
    localparam int M_VID  = 1;
    localparam int M_CPU  = 2;
    localparam int M_DMA  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  vid_phase;
    logic        vid_en;
    logic [13:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [13:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [7:0]  mem     [0:16383];
    logic [7:0]  ref_mem [0:16383];

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;
    bit vid_rand = 1'b1;

    typedef struct {
        bit         we;
        logic [7:0] data;
    } exp_t;
    exp_t cpu_q[$];
    exp_t dma_q[$];

    int         m_prev;
    int         m_last;
    logic [7:0] m_vid_cur;
    logic [7:0] m_s1;
    bit         m_s1v;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_vid_phase (vid_phase),
        .i_vid_en    (vid_en),
        .i_vid_addr  (vid_addr),
        .o_vid_data  (vid_data),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_ack   (cpu_ack),
        .i_dma_req   (dma_req),
        .i_dma_we    (dma_we),
        .i_dma_addr  (dma_addr),
        .i_dma_wdata (dma_wdata),
        .o_dma_rdata (dma_rdata),
        .o_dma_ack   (dma_ack),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    task automatic chk(input string nm, input int act_v, input int req_v);
        checks++;
        if (act_v != req_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act_v, req_v, $time);
        end
    endtask

    // Synchronous single-port RAM, read-first, 1-cycle read latency
    initial begin
        for (int k = 0; k < 16384; k++) mem[k] = k[7:0];
        forever begin
            @(posedge clk);
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_wdata;
        end
    end

    // Pixel-group phase and scanout address; scanout reads only the never-written 0x3xxx region
    initial begin
        vid_phase = 2'd0;
        vid_en    = 1'b1;
        vid_addr  = 14'h3025;
        forever begin
            @(posedge clk);
            #1;
            vid_phase = vid_phase + 2'd1;
            if (vid_phase == 2'd0) begin
                vid_addr = {2'b11, 12'($urandom)};
                vid_en   = vid_rand && ($urandom_range(0, 4) != 0);
            end
        end
    end

    // Monitor and reference model: slot rules, turn-taking and data checks
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin : mon
                int   own;
                bit   ec, ed;
                exp_t e;
                chk("cpu_ack", cpu_ack, m_prev == M_CPU);
                chk("dma_ack", dma_ack, m_prev == M_DMA);
                if (cpu_ack) begin
                    if (cpu_q.size() == 0) chk("cpu_q_empty", 1, 0);
                    else begin
                        e = cpu_q.pop_front();
                        if (!e.we) chk("cpu_rdata", cpu_rdata, e.data);
                    end
                end
                if (dma_ack) begin
                    if (dma_q.size() == 0) chk("dma_q_empty", 1, 0);
                    else begin
                        e = dma_q.pop_front();
                        if (!e.we) chk("dma_rdata", dma_rdata, e.data);
                    end
                end
                chk("vid_data", vid_data, m_vid_cur);
                if (m_s1v) m_vid_cur = m_s1;

                ec = cpu_req && (m_prev != M_CPU);
                ed = dma_req && (m_prev != M_DMA);
                if (vid_en && vid_phase == 2'd0) own = M_VID;
                else if (ec && ed)               own = (m_last == M_CPU) ? M_DMA : M_CPU;
                else if (ec)                     own = M_CPU;
                else if (ed)                     own = M_DMA;
                else                             own = M_NONE;

                m_s1v = (own == M_VID);
                m_s1  = ref_mem[vid_addr];
                case (own)
                    M_VID: begin
                        chk("ram_addr_vid", ram_addr, vid_addr);
                        chk("ram_we_vid", ram_we, 0);
                    end
                    M_CPU: begin
                        chk("ram_addr_cpu", ram_addr, cpu_addr);
                        chk("ram_we_cpu", ram_we, cpu_we);
                        if (cpu_we) chk("ram_wdata_cpu", ram_wdata, cpu_wdata);
                    end
                    M_DMA: begin
                        chk("ram_addr_dma", ram_addr, dma_addr);
                        chk("ram_we_dma", ram_we, dma_we);
                        if (dma_we) chk("ram_wdata_dma", ram_wdata, dma_wdata);
                    end
                    default: chk("ram_we_idle", ram_we, 0);
                endcase
                if (own == M_CPU || own == M_DMA) m_last = own;
                m_prev = own;
            end
        end
    end

    // One requester: random reads/writes in its own region, random gaps, req held to ack
    task automatic run_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          k;
            bit          we_v;
            logic [13:0] a;
            logic [7:0]  d;
            exp_t        e;
            gap  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            we_v = $urandom_range(0, 1);
            a    = {(p == 0) ? 2'b00 : 2'b01, 8'h00, 4'($urandom_range(0, 15))};
            d    = 8'($urandom);
            if (gap > 0) begin
                if (p == 0) cpu_req = 1'b0; else dma_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            e.we   = we_v;
            e.data = ref_mem[a];
            if (we_v) ref_mem[a] = d;
            if (p == 0) begin
                cpu_req = 1'b1; cpu_we = we_v; cpu_addr = a; cpu_wdata = d;
                cpu_q.push_back(e);
            end else begin
                dma_req = 1'b1; dma_we = we_v; dma_addr = a; dma_wdata = d;
                dma_q.push_back(e);
            end
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!((p == 0) ? cpu_ack : dma_ack) && k < 12);
            chk((p == 0) ? "cpu_ack_seen" : "dma_ack_seen", (p == 0) ? cpu_ack : dma_ack, 1);
            @(posedge clk);
            #1;
        end
        if (p == 0) cpu_req = 1'b0; else dma_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        for (int k = 0; k < 16384; k++) ref_mem[k] = k[7:0];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_ram_we", ram_we, 0);

        @(posedge clk);
        #1;
        m_prev    = M_NONE;
        m_last    = M_DMA;
        m_vid_cur = 8'h00;
        m_s1v     = 1'b0;
        rst_n     = 1'b1;
        mon_on    = 1'b1;

        fork
            run_port(0, 60);
            run_port(1, 60);
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("dma_q_drained", dma_q.size(), 0);

        // Reset while a CPU read is completing
        mon_on   = 1'b0;
        vid_rand = 1'b0;
        vid_en   = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0003;
        @(posedge clk);
        #1;
        chk("pre_rst_cpu_ack", cpu_ack, 1);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h1003; dma_wdata = 8'h5A;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cpu_ack", cpu_ack, 0);
        chk("async_rst_ram_we", ram_we, 0);
        chk("async_rst_cpu_rdata", cpu_rdata, 0);
        chk("async_rst_dma_rdata", dma_rdata, 0);
        chk("async_rst_vid_data", vid_data, 0);
        @(posedge clk);
        #1;
        chk("in_rst_cpu_ack", cpu_ack, 0);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0005;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h1006;
        @(posedge clk);
        #1;
        chk("tie_cpu_first_ack", cpu_ack, 1);
        chk("tie_dma_waits", dma_ack, 0);
        chk("tie_cpu_rdata", cpu_rdata, ref_mem[14'h0005]);
        @(posedge clk);
        #1;
        chk("tie_dma_second_ack", dma_ack, 1);
        chk("tie_cpu_no_ack", cpu_ack, 0);
        chk("tie_dma_rdata", dma_rdata, ref_mem[14'h1006]);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("cpu_rdata_held", cpu_rdata, ref_mem[14'h0005]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
